// File: rtl/fft_butterfly_pipe_if.sv
// Operand, result and overflow-status bundle for fft_butterfly_pipe.
// The slave modport is the butterfly side; the master modport is the upstream/downstream side.
interface fft_butterfly_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_w;
    logic             in_inverse;
    logic             in_scale;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic             out_ovf;
    logic             ovf_sticky;
    logic             ovf_clr;

    modport master (
        output in_valid, in_a, in_b, in_w, in_inverse, in_scale, out_ready, ovf_clr,
        input  in_ready, out_valid, out_x, out_y, out_ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, in_a, in_b, in_w, in_inverse, in_scale, out_ready, ovf_clr,
        output in_ready, out_valid, out_x, out_y, out_ovf, ovf_sticky
    );
endinterface

// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly (X = A + B*W, Y = A - B*W): S1 multiply, S2 add/sub, S3 scale/limit.
// Build option FFT_BUTTERFLY_SATURATE_EN: clamp overflowing components instead of wrapping them.
module fft_butterfly_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fft_butterfly_pipe_if.slave  bus
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * H + 2;
    localparam int EW = H + 2;
    localparam int LW = EW + 1;
    localparam logic signed [PW-1:0] RND_C = {{(PW-1){1'b0}}, 1'b1} << (H - 2);
    localparam logic signed [LW-1:0] ONE_L = {{(LW-1){1'b0}}, 1'b1};

    // Optional halving with round half up, widened so v + 1 cannot wrap.
    function automatic logic signed [LW-1:0] scale_comp(input logic signed [EW-1:0] v, input logic sc);
        logic signed [LW-1:0] ext;
        ext = LW'(v);
        if (sc) begin
            return (ext + ONE_L) >>> 1;
        end else begin
            return ext;
        end
    endfunction

    // Returns {overflow, limited H-bit component}.
    function automatic logic [H:0] limit_comp(input logic signed [LW-1:0] v);
        logic         fits;
        logic [H-1:0] val;
        fits = (&v[LW-1:H-1]) | ~(|v[LW-1:H-1]);
`ifdef FFT_BUTTERFLY_SATURATE_EN
        if (fits) begin
            val = v[H-1:0];
        end else if (v[LW-1]) begin
            val = {1'b1, {(H-1){1'b0}}};
        end else begin
            val = {1'b0, {(H-1){1'b1}}};
        end
`else
        val = v[H-1:0];
`endif
        return {~fits, val};
    endfunction

    logic                 adv_s;
    logic signed [H-1:0]  br_s, bi_s, wr_s, wi_s;
    logic signed [H:0]    wi_ext_s, wi_eff_s;
    logic signed [PW-1:0] prod_rr_s, prod_ii_s, prod_ri_s, prod_ir_s;
    logic signed [EW-1:0] tr_s, ti_s;
    logic signed [H-1:0]  ar1_s, ai1_s;
    logic signed [EW-1:0] xr_s, xi_s, yr_s, yi_s;
    logic [H:0]           lim_xr_s, lim_xi_s, lim_yr_s, lim_yi_s;

    logic                 s1_valid_r, s1_scale_r;
    logic [WIDTH-1:0]     s1_a_r;
    logic signed [EW-1:0] s1_tr_r, s1_ti_r;
    logic                 s2_valid_r, s2_scale_r;
    logic signed [EW-1:0] s2_xr_r, s2_xi_r, s2_yr_r, s2_yi_r;
    logic                 s3_valid_r, s3_ovf_r;
    logic [WIDTH-1:0]     s3_x_r, s3_y_r;
    logic                 sticky_r;

    // A stall freezes every stage, bubbles included.
    assign adv_s        = bus.out_ready | ~s3_valid_r;
    assign bus.in_ready = adv_s;

    assign br_s     = bus.in_b[H-1:0];
    assign bi_s     = bus.in_b[WIDTH-1:H];
    assign wr_s     = bus.in_w[H-1:0];
    assign wi_s     = bus.in_w[WIDTH-1:H];
    assign wi_ext_s = {wi_s[H-1], wi_s};

    // S1 combinational: full-precision complex multiply, one rounding per component.
    always_comb begin
        wi_eff_s  = bus.in_inverse ? -wi_ext_s : wi_ext_s;
        prod_rr_s = PW'(br_s) * PW'(wr_s);
        prod_ii_s = PW'(bi_s) * PW'(wi_eff_s);
        prod_ri_s = PW'(br_s) * PW'(wi_eff_s);
        prod_ir_s = PW'(bi_s) * PW'(wr_s);
        tr_s      = EW'((prod_rr_s - prod_ii_s + RND_C) >>> (H - 1));
        ti_s      = EW'((prod_ri_s + prod_ir_s + RND_C) >>> (H - 1));
    end

    assign ar1_s = s1_a_r[H-1:0];
    assign ai1_s = s1_a_r[WIDTH-1:H];

    // S2 combinational: sum and difference at full H+2 bits.
    always_comb begin
        xr_s = EW'(ar1_s) + s1_tr_r;
        xi_s = EW'(ai1_s) + s1_ti_r;
        yr_s = EW'(ar1_s) - s1_tr_r;
        yi_s = EW'(ai1_s) - s1_ti_r;
    end

    // S3 combinational: optional halving, then limit each component to H bits.
    always_comb begin
        lim_xr_s = limit_comp(scale_comp(s2_xr_r, s2_scale_r));
        lim_xi_s = limit_comp(scale_comp(s2_xi_r, s2_scale_r));
        lim_yr_s = limit_comp(scale_comp(s2_yr_r, s2_scale_r));
        lim_yi_s = limit_comp(scale_comp(s2_yi_r, s2_scale_r));
    end

    // Three-stage pipeline register, advancing as a whole on adv_s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_scale_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_tr_r    <= {EW{1'b0}};
            s1_ti_r    <= {EW{1'b0}};
            s2_valid_r <= 1'b0;
            s2_scale_r <= 1'b0;
            s2_xr_r    <= {EW{1'b0}};
            s2_xi_r    <= {EW{1'b0}};
            s2_yr_r    <= {EW{1'b0}};
            s2_yi_r    <= {EW{1'b0}};
            s3_valid_r <= 1'b0;
            s3_ovf_r   <= 1'b0;
            s3_x_r     <= {WIDTH{1'b0}};
            s3_y_r     <= {WIDTH{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= bus.in_valid;
            s1_scale_r <= bus.in_scale;
            s1_a_r     <= bus.in_a;
            s1_tr_r    <= tr_s;
            s1_ti_r    <= ti_s;
            s2_valid_r <= s1_valid_r;
            s2_scale_r <= s1_scale_r;
            s2_xr_r    <= xr_s;
            s2_xi_r    <= xi_s;
            s2_yr_r    <= yr_s;
            s2_yi_r    <= yi_s;
            s3_valid_r <= s2_valid_r;
            s3_ovf_r   <= lim_xr_s[H] | lim_xi_s[H] | lim_yr_s[H] | lim_yi_s[H];
            s3_x_r     <= {lim_xi_s[H-1:0], lim_xr_s[H-1:0]};
            s3_y_r     <= {lim_yi_s[H-1:0], lim_yr_s[H-1:0]};
        end
    end

    // Sticky overflow: a consumed overflowing result beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_r <= 1'b0;
        end else if (s3_valid_r & bus.out_ready & s3_ovf_r) begin
            sticky_r <= 1'b1;
        end else if (bus.ovf_clr) begin
            sticky_r <= 1'b0;
        end
    end

    assign bus.out_valid  = s3_valid_r;
    assign bus.out_x      = s3_x_r;
    assign bus.out_y      = s3_y_r;
    assign bus.out_ovf    = s3_ovf_r;
    assign bus.ovf_sticky = sticky_r;
endmodule
